id_decode_stage: RTL
====================

Name: id_decode_stage

Overview:
- Instruction-decode stage sitting between the IF/ID register and the ID/EXE pipeline register.
- Decodes a 32-bit MIPS-subset instruction into the ALU and memory control bundle that the ID/EXE register captures.
- Owns the 32-entry register file: read ports for ID, write port from WB.
- Detects load-use hazards and converts decode into bubbles on stall or flush.

Parameters:
- DSIZE, 32, data width of registers and immediates
- ASIZE, 5, register address width (2**ASIZE entries)
- ISIZE, 32, instruction and PC width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_in  in  ISIZE  instruction from IF/ID
- PC_in  in  ISIZE  PC of instr_in
- wb_wen  in  1  WB register write enable
- wb_waddr  in  ASIZE  WB destination register
- wb_wdata  in  DSIZE  WB write data
- ex_memRead  in  1  memRead currently held in ID/EXE
- ex_waddr  in  ASIZE  waddr currently held in ID/EXE
- flush  in  1  branch/jump taken in EXE; kill the instruction in ID
- rdata1_out  out  DSIZE  rs value
- rdata2_out  out  DSIZE  rt value
- imm_out  out  DSIZE  extended immediate
- opcode_out  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- alusrc_out  out  1  1 = ALU B operand is imm
- waddr_out  out  ASIZE  destination register
- wen_out, memWrite_out, memRead_out, memToReg_out, branch_out, jal_out  out  1 each  control bits
- PC_out  out  ISIZE  PC_in passthrough
- stall  out  1  hold PC and IF/ID this cycle
- illegal  out  1  unsupported opcode/funct in ID
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- Field positions: op = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- R-type (op 0x00), funct 0x20/0x22/0x24/0x25/0x2A maps to ADD/SUB/AND/OR/SLT.
  - waddr = rd, wen = 1, alusrc = 0.
- addi 0x08: ADD, alusrc = 1, waddr = rt, wen = 1.
- lw 0x23: ADD, alusrc = 1, memRead = 1, memToReg = 1, wen = 1, waddr = rt.
- sw 0x2B: ADD, alusrc = 1, memWrite = 1, wen = 0.
- beq 0x04: SUB, branch = 1, alusrc = 0, wen = 0.
- jal 0x03: jal = 1, wen = 1, waddr = 31, imm = zero-extended instr[25:0].
- All other instructions: imm = sign-extended instr[15:0].
- Unsupported op or funct: illegal = 1; all control bits 0 (bubble).
- Decode outputs are combinational from instr_in and the register file. The ID/EXE register supplies the pipeline latency.
- Register file writes:
  - Written at posedge clk when wb_wen = 1 and wb_waddr != 0.
  - Register 0 always reads 0.
- Register file reads:
  - Write-first bypass: if wb_wen = 1, wb_waddr != 0, and wb_waddr equals the read address, the read returns wb_wdata in the same cycle.
- Load-use hazard:
  - Condition: ex_memRead = 1, ex_waddr != 0, and ex_waddr == rs, or ex_waddr == rt when rt is a source.
  - rt is a source for R-type, sw and beq; it is not a source for addi, lw or jal.
  - Response: stall = 1, and the bubble is forced.
- Bubble forcing: when stall = 1 or flush = 1, force wen, memWrite, memRead, memToReg, branch and jal to 0. Data fields still pass through.
- flush has priority over stall: when flush = 1, stall = 0.
- stall_count increments each cycle stall = 1 and saturates at 0xFFFF.
- Reset (rst = 1 at posedge):
  - All 32 registers are cleared to 0 in one cycle.
  - stall_count is cleared to 0.
  - During reset, all control outputs and stall read 0. Data outputs are don't-care but are driven 0.
- Reset mid-stall: stall deasserts in the cycle rst is high. An in-flight WB write in that cycle is discarded.
- Simultaneous WB write and read of the same register: the new value is returned (bypass) and stored.

Test Plan:
- Reset, then decode add r3,r1,r2 (0x00221820) -> opcode 000, waddr 3, wen 1, alusrc 0, rdata1 = rdata2 = 0, stall 0.
- WB writes r1 = 0x0000_00AA, and in the same cycle ID decodes addi r2,r1,-4 (0x2022FFFC) -> rdata1 = 0xAA via bypass, imm 0xFFFFFFFC, alusrc 1, waddr 2.
- ex_memRead = 1, ex_waddr = 5, ID decodes sw r5,0(r6) (rt = 5) -> stall 1, memWrite 0, stall_count 0 to 1.
  - Same hazard setup with addi r5,r6,1 (rs = 6, target r5) -> stall 0.
- flush = 1 together with a load-use hazard on beq -> stall 0, branch 0, all control 0.
- jal 0x0C000010 -> jal 1, waddr 31, wen 1, imm 0x00000010, PC_out = PC_in.
  - Unsupported op 0x3F -> illegal 1, all control 0.
- WB write to r0 with data 0xFFFFFFFF, then read r0 -> 0.
  - Assert rst during a stall -> stall 0 in that cycle; registers read 0 afterwards.

Source files
------------

// File: rtl/id_decode_stage.sv
// id_decode_stage
//
// Instruction-decode stage between the IF/ID and ID/EXE pipeline registers.
// Decodes a 32-bit MIPS-subset instruction into the ALU/memory control
// bundle, owns the 32-entry register file, detects load-use hazards and
// turns the decoded instruction into a bubble on stall or flush.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_in, PC_in   instruction and its PC from IF/ID
//   wb_wen/waddr/wdata  register-file write port driven by WB
//   ex_memRead, ex_waddr  load currently held in ID/EXE (hazard check)
//   flush             taken branch/jump in EXE, kill the ID instruction
//   rdata1/2_out      rs / rt values (write-first bypass from WB)
//   imm_out           sign-extended imm16, or zero-extended target for jal
//   opcode_out        ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
//   alusrc_out        1 selects imm as the ALU B operand
//   waddr_out         destination register
//   wen/memWrite/memRead/memToReg/branch/jal_out  control bits
//   PC_out            PC_in passthrough
//   stall             hold PC and IF/ID this cycle
//   illegal           unsupported opcode/funct in ID
//   stall_count       saturating count of stall cycles
module id_decode_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ISIZE-1:0] instr_in,
  input  logic [ISIZE-1:0] PC_in,
  input  logic             wb_wen,
  input  logic [ASIZE-1:0] wb_waddr,
  input  logic [DSIZE-1:0] wb_wdata,
  input  logic             ex_memRead,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             flush,
  output logic [DSIZE-1:0] rdata1_out,
  output logic [DSIZE-1:0] rdata2_out,
  output logic [DSIZE-1:0] imm_out,
  output logic [2:0]       opcode_out,
  output logic             alusrc_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             memWrite_out,
  output logic             memRead_out,
  output logic             memToReg_out,
  output logic             branch_out,
  output logic             jal_out,
  output logic [ISIZE-1:0] PC_out,
  output logic             stall,
  output logic             illegal,
  output logic [15:0]      stall_count
);

  localparam int NREGS = 2 ** ASIZE;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [ASIZE-1:0] rs;
  logic [ASIZE-1:0] rt;
  logic [ASIZE-1:0] rd;

  assign op    = instr_in[31:26];
  assign rs    = instr_in[21 +: ASIZE];
  assign rt    = instr_in[16 +: ASIZE];
  assign rd    = instr_in[11 +: ASIZE];
  assign funct = instr_in[5:0];

  logic [DSIZE-1:0] regs [NREGS];

  // Reset clears every register in one cycle and wins over a pending WB
  // write; register 0 is never written so it always holds zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_wen && wb_waddr != '0) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  // Write-first bypass so an instruction reading the register WB is
  // writing this cycle sees the new value.
  logic             wb_live;
  logic [DSIZE-1:0] rd1;
  logic [DSIZE-1:0] rd2;

  assign wb_live = wb_wen && (wb_waddr != '0);
  assign rd1 = (rs == '0) ? '0 : (wb_live && wb_waddr == rs) ? wb_wdata : regs[rs];
  assign rd2 = (rt == '0) ? '0 : (wb_live && wb_waddr == rt) ? wb_wdata : regs[rt];

  // Raw decode before any bubble forcing.
  logic [2:0]       dec_alu;
  logic             dec_alusrc;
  logic [ASIZE-1:0] dec_waddr;
  logic             dec_wen;
  logic             dec_memWrite;
  logic             dec_memRead;
  logic             dec_memToReg;
  logic             dec_branch;
  logic             dec_jal;
  logic             dec_illegal;
  logic             rt_is_src;
  logic [DSIZE-1:0] dec_imm;

  always_comb begin
    dec_alu      = ALU_ADD;
    dec_alusrc   = 1'b0;
    dec_waddr    = '0;
    dec_wen      = 1'b0;
    dec_memWrite = 1'b0;
    dec_memRead  = 1'b0;
    dec_memToReg = 1'b0;
    dec_branch   = 1'b0;
    dec_jal      = 1'b0;
    dec_illegal  = 1'b0;
    rt_is_src    = 1'b0;
    dec_imm      = {{(DSIZE-16){instr_in[15]}}, instr_in[15:0]};
    case (op)
      OP_RTYPE: begin
        rt_is_src = 1'b1;
        dec_waddr = rd;
        dec_wen   = 1'b1;
        case (funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec_alusrc = 1'b1;
        dec_waddr  = rt;
        dec_wen    = 1'b1;
      end
      OP_LW: begin
        dec_alusrc   = 1'b1;
        dec_waddr    = rt;
        dec_wen      = 1'b1;
        dec_memRead  = 1'b1;
        dec_memToReg = 1'b1;
      end
      OP_SW: begin
        rt_is_src    = 1'b1;
        dec_alusrc   = 1'b1;
        dec_waddr    = rt;
        dec_memWrite = 1'b1;
      end
      OP_BEQ: begin
        rt_is_src  = 1'b1;
        dec_alu    = ALU_SUB;
        dec_branch = 1'b1;
      end
      OP_JAL: begin
        dec_jal   = 1'b1;
        dec_wen   = 1'b1;
        dec_waddr = '1;
        dec_imm   = {{(DSIZE-26){1'b0}}, instr_in[25:0]};
      end
      default: dec_illegal = 1'b1;
    endcase
    // An unsupported instruction becomes a full bubble.
    if (dec_illegal) begin
      dec_alu      = ALU_ADD;
      dec_alusrc   = 1'b0;
      dec_waddr    = '0;
      dec_wen      = 1'b0;
      dec_memWrite = 1'b0;
      dec_memRead  = 1'b0;
      dec_memToReg = 1'b0;
      dec_branch   = 1'b0;
      dec_jal      = 1'b0;
    end
  end

  // Load-use hazard: the load in EXE targets a register this instruction
  // reads. Flush and reset both override the stall.
  logic hazard;
  logic stall_int;
  logic bubble;

  assign hazard = ex_memRead && (ex_waddr != '0) &&
                  ((ex_waddr == rs) || (rt_is_src && ex_waddr == rt));
  assign stall_int = hazard && !flush && !rst;
  assign bubble    = stall_int || flush || rst;

  always_comb begin
    rdata1_out   = rst ? '0 : rd1;
    rdata2_out   = rst ? '0 : rd2;
    imm_out      = rst ? '0 : dec_imm;
    opcode_out   = rst ? 3'b000 : dec_alu;
    alusrc_out   = rst ? 1'b0 : dec_alusrc;
    waddr_out    = rst ? '0 : dec_waddr;
    PC_out       = rst ? '0 : PC_in;
    illegal      = rst ? 1'b0 : dec_illegal;
    wen_out      = dec_wen      && !bubble;
    memWrite_out = dec_memWrite && !bubble;
    memRead_out  = dec_memRead  && !bubble;
    memToReg_out = dec_memToReg && !bubble;
    branch_out   = dec_branch   && !bubble;
    jal_out      = dec_jal      && !bubble;
    stall        = stall_int;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_int && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
